otter_control_unit: RTL and testbench

//  Multi-cycle control unit (FSM + instruction decoder) for the OTTER RV32I MCU.

---
 rtl/otter_pkg.sv | 80 ++++++++
 rtl/otter_cu_dcdr.sv | 123 ++++++++++++
 rtl/otter_control_unit.sv | 115 +++++++++++
 tb/tb_otter_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared encodings for the OTTER control path.
//   - opcode constants (RV32I major opcodes)
//   - FSM state enum for the multi-cycle control unit
//   - ALU_FUNC constants (the ALU decodes the same values)
//   - operand, PC and writeback select constants
//   - dcdr_t: the decoder's execute-phase control bundle
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_COPY = 4'b1001;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_UIMM = 2'd1;
  localparam logic [1:0] SRCA_NRS1 = 2'd2;

  localparam logic [2:0] SRCB_RS2  = 3'd0;
  localparam logic [2:0] SRCB_IIMM = 3'd1;
  localparam logic [2:0] SRCB_SIMM = 3'd2;
  localparam logic [2:0] SRCB_PC   = 3'd3;
  localparam logic [2:0] SRCB_CSR  = 3'd4;

  localparam logic [2:0] PCS_PLUS4  = 3'd0;
  localparam logic [2:0] PCS_JALR   = 3'd1;
  localparam logic [2:0] PCS_BRANCH = 3'd2;
  localparam logic [2:0] PCS_JAL    = 3'd3;
  localparam logic [2:0] PCS_MTVEC  = 3'd4;
  localparam logic [2:0] PCS_MEPC   = 3'd5;

  localparam logic [1:0] WR_PC4 = 2'd0;
  localparam logic [1:0] WR_CSR = 2'd1;
  localparam logic [1:0] WR_MEM = 2'd2;
  localparam logic [1:0] WR_ALU = 2'd3;

  localparam logic [31:0] MRET_INSN = 32'h3020_0073;

  typedef struct packed {
    logic       pc_we;
    logic       rf_we;
    logic       mem_rden2;
    logic       mem_we2;
    logic       csr_we;
    logic       mret_exec;
    logic       is_load;
    logic [3:0] alu_func;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [2:0] pc_source;
    logic [1:0] rf_wr_sel;
  } dcdr_t;

endpackage

// File: rtl/otter_cu_dcdr.sv
// otter_cu_dcdr: combinational instruction decoder.
// Produces the control bundle that applies while the FSM sits in ST_EXEC.
// Ports:
//   ir      in  32  current instruction
//   br_eq   in  1   rs1 == rs2
//   br_lt   in  1   signed rs1 < rs2
//   br_ltu  in  1   unsigned rs1 < rs2
//   ctrl    out     dcdr_t execute-phase controls (+ is_load flag for the FSM)
module otter_cu_dcdr
  import otter_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output dcdr_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_taken;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = ~br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = ~br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = ~br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    // Default is the NOP behaviour used for anything unrecognised:
    // advance PC by 4 and change nothing else.
    ctrl           = '0;
    ctrl.pc_we     = 1'b1;
    ctrl.pc_source = PCS_PLUS4;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_func  = {ir[30], funct3};
        ctrl.srca      = SRCA_RS1;
        ctrl.srcb      = SRCB_RS2;
        ctrl.rf_we     = 1'b1;
        ctrl.rf_wr_sel = WR_ALU;
      end
      OPC_OP_IMM: begin
        // IR[30] is part of the immediate except for the SRLI/SRAI pair.
        ctrl.alu_func  = {(funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
        ctrl.srcb      = SRCB_IIMM;
        ctrl.rf_we     = 1'b1;
        ctrl.rf_wr_sel = WR_ALU;
      end
      OPC_LUI: begin
        ctrl.alu_func  = ALU_COPY;
        ctrl.srca      = SRCA_UIMM;
        ctrl.rf_we     = 1'b1;
        ctrl.rf_wr_sel = WR_ALU;
      end
      OPC_AUIPC: begin
        ctrl.alu_func  = ALU_ADD;
        ctrl.srca      = SRCA_UIMM;
        ctrl.srcb      = SRCB_PC;
        ctrl.rf_we     = 1'b1;
        ctrl.rf_wr_sel = WR_ALU;
      end
      OPC_LOAD: begin
        // PC is held; it advances when the writeback cycle completes.
        ctrl.alu_func  = ALU_ADD;
        ctrl.srcb      = SRCB_IIMM;
        ctrl.mem_rden2 = 1'b1;
        ctrl.pc_we     = 1'b0;
        ctrl.is_load   = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_func = ALU_ADD;
        ctrl.srcb     = SRCB_SIMM;
        ctrl.mem_we2  = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.pc_source = br_taken ? PCS_BRANCH : PCS_PLUS4;
      end
      OPC_JAL: begin
        ctrl.pc_source = PCS_JAL;
        ctrl.rf_we     = 1'b1;
        ctrl.rf_wr_sel = WR_PC4;
      end
      OPC_JALR: begin
        ctrl.pc_source = PCS_JALR;
        ctrl.rf_we     = 1'b1;
        ctrl.rf_wr_sel = WR_PC4;
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b001, 3'b010, 3'b011: begin
            ctrl.csr_we    = 1'b1;
            ctrl.rf_we     = 1'b1;
            ctrl.rf_wr_sel = WR_CSR;
            ctrl.srcb      = SRCB_CSR;
            ctrl.srca      = (funct3 == 3'b011) ? SRCA_NRS1 : SRCA_RS1;
            ctrl.alu_func  = (funct3 == 3'b001) ? ALU_COPY :
                             (funct3 == 3'b010) ? ALU_OR : ALU_AND;
          end
          3'b000: begin
            if (ir == MRET_INSN) begin
              ctrl.mret_exec = 1'b1;
              ctrl.pc_source = PCS_MEPC;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/otter_control_unit.sv
// otter_control_unit: multi-cycle FSM sequencing the OTTER datapath.
// Ports:
//   CLK, RST (sync, active-high)      clock / reset
//   IR, BR_EQ, BR_LT, BR_LTU          instruction and branch compare flags
//   INTR, MIE                         interrupt request and global enable
//   PC_WE .. MRET_EXEC                enables and strobes (0 while RST is high)
//   ALU_FUNC, ALU_SRCA, ALU_SRCB      ALU op and operand selects
//   PC_SOURCE, RF_WR_SEL              next-PC and writeback selects
//   state_dbg                         current FSM state, for observation
module otter_control_unit
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IR,
  input  logic        BR_EQ,
  input  logic        BR_LT,
  input  logic        BR_LTU,
  input  logic        INTR,
  input  logic        MIE,
  output logic        PC_WE,
  output logic        RF_WE,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        CSR_WE,
  output logic        INT_TAKEN,
  output logic        MRET_EXEC,
  output logic [3:0]  ALU_FUNC,
  output logic [1:0]  ALU_SRCA,
  output logic [2:0]  ALU_SRCB,
  output logic [2:0]  PC_SOURCE,
  output logic [1:0]  RF_WR_SEL,
  output state_e      state_dbg
);

  state_e state_q, state_d;
  dcdr_t  ctrl;
  logic   take_intr;

  otter_cu_dcdr u_dcdr (
    .ir     (IR),
    .br_eq  (BR_EQ),
    .br_lt  (BR_LT),
    .br_ltu (BR_LTU),
    .ctrl   (ctrl)
  );

  assign take_intr = INTR & MIE;
  assign state_dbg = state_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      // A load defers any interrupt until its writeback has finished.
      ST_EXEC:  state_d = ctrl.is_load ? ST_WB : (take_intr ? ST_INTR : ST_FETCH);
      ST_WB:    state_d = take_intr ? ST_INTR : ST_FETCH;
      ST_INTR:  state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    PC_WE     = 1'b0;
    RF_WE     = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    ALU_FUNC  = 4'd0;
    ALU_SRCA  = 2'd0;
    ALU_SRCB  = 3'd0;
    PC_SOURCE = 3'd0;
    RF_WR_SEL = 2'd0;
    if (!RST) begin
      case (state_q)
        ST_FETCH: MEM_RDEN1 = 1'b1;
        ST_EXEC: begin
          PC_WE     = ctrl.pc_we;
          RF_WE     = ctrl.rf_we;
          MEM_RDEN2 = ctrl.mem_rden2;
          MEM_WE2   = ctrl.mem_we2;
          CSR_WE    = ctrl.csr_we;
          MRET_EXEC = ctrl.mret_exec;
          ALU_FUNC  = ctrl.alu_func;
          ALU_SRCA  = ctrl.srca;
          ALU_SRCB  = ctrl.srcb;
          PC_SOURCE = ctrl.pc_source;
          RF_WR_SEL = ctrl.rf_wr_sel;
        end
        ST_WB: begin
          RF_WE     = 1'b1;
          RF_WR_SEL = WR_MEM;
          PC_WE     = 1'b1;
          PC_SOURCE = PCS_PLUS4;
        end
        ST_INTR: begin
          INT_TAKEN = 1'b1;
          PC_WE     = 1'b1;
          PC_SOURCE = PCS_MTVEC;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_control_unit.sv
// Directed bench for otter_control_unit. Each step pushes the expected
// output vector {state, strobes, selects} onto exp_q and compares it with
// the DUT outputs on the falling edge.
module tb_otter_control_unit;
  import otter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        br_eq, br_lt, br_ltu, intr, mie;
  logic        pc_we, rf_we, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec;
  logic [3:0]  alu_func;
  logic [1:0]  alu_srca;
  logic [2:0]  alu_srcb;
  logic [2:0]  pc_source;
  logic [1:0]  rf_wr_sel;
  state_e      state_dbg;

  logic [23:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  localparam logic [31:0] I_SUB   = 32'h40B5_0533;
  localparam logic [31:0] I_ADD   = 32'h0020_8033;
  localparam logic [31:0] I_SRAI  = 32'h4020_D093;
  localparam logic [31:0] I_SLLI  = 32'h0020_9093;
  localparam logic [31:0] I_LW    = 32'h0000_A103;
  localparam logic [31:0] I_SW    = 32'h0011_2023;
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;
  localparam logic [31:0] I_JAL   = 32'h0000_006F;
  localparam logic [31:0] I_CSRRC = 32'h3001_30F3;
  localparam logic [31:0] I_MRET  = 32'h3020_0073;

  always #5 clk = ~clk;

  otter_control_unit dut (
    .CLK       (clk),
    .RST       (rst),
    .IR        (ir),
    .BR_EQ     (br_eq),
    .BR_LT     (br_lt),
    .BR_LTU    (br_ltu),
    .INTR      (intr),
    .MIE       (mie),
    .PC_WE     (pc_we),
    .RF_WE     (rf_we),
    .MEM_RDEN1 (mem_rden1),
    .MEM_RDEN2 (mem_rden2),
    .MEM_WE2   (mem_we2),
    .CSR_WE    (csr_we),
    .INT_TAKEN (int_taken),
    .MRET_EXEC (mret_exec),
    .ALU_FUNC  (alu_func),
    .ALU_SRCA  (alu_srca),
    .ALU_SRCB  (alu_srcb),
    .PC_SOURCE (pc_source),
    .RF_WR_SEL (rf_wr_sel),
    .state_dbg (state_dbg)
  );

  // Vector layout: st[2] pc_we rf_we rden1 rden2 we2 csr_we int mret func[4] a[2] b[3] pcs[3] wsel[2]
  function automatic logic [23:0] ev(input logic [1:0] st, input logic [7:0] en,
                                     input logic [3:0] func, input logic [1:0] a,
                                     input logic [2:0] b, input logic [2:0] pcs,
                                     input logic [1:0] wsel);
    return {st, en, func, a, b, pcs, wsel};
  endfunction

  // Enable bit positions inside en[7:0]
  localparam logic [7:0] E_PC   = 8'b1000_0000;
  localparam logic [7:0] E_RF   = 8'b0100_0000;
  localparam logic [7:0] E_RD1  = 8'b0010_0000;
  localparam logic [7:0] E_RD2  = 8'b0001_0000;
  localparam logic [7:0] E_WE2  = 8'b0000_1000;
  localparam logic [7:0] E_CSR  = 8'b0000_0100;
  localparam logic [7:0] E_INT  = 8'b0000_0010;
  localparam logic [7:0] E_MRET = 8'b0000_0001;

  function automatic logic [23:0] fetch_v();
    return ev(2'd0, E_RD1, 4'd0, 2'd0, 3'd0, 3'd0, 2'd0);
  endfunction

  // Compare one cycle of DUT output against the head of the queue.
  task automatic step(input string tag);
    logic [23:0] obs, exp_v;
    @(negedge clk);
    obs = {state_dbg, pc_we, rf_we, mem_rden1, mem_rden2, mem_we2, csr_we,
           int_taken, mret_exec, alu_func, alu_srca, alu_srcb, pc_source, rf_wr_sel};
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      total++;
      assert (obs === exp_v) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ir = 32'h0; br_eq = 0; br_lt = 0; br_ltu = 0; intr = 0; mie = 0;
    @(posedge clk); #1;

    // Reset state
    exp_q.push_back(ev(2'd0, 8'h00, 4'd0, 2'd0, 3'd0, 3'd0, 2'd0)); step("reset");
    rst = 1'b0;

    // sub
    ir = I_SUB;
    exp_q.push_back(fetch_v()); step("sub_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_RF, 4'b1000, 2'd0, 3'd0, 3'd0, 2'd3)); step("sub_exec");

    // srai / slli
    ir = I_SRAI;
    exp_q.push_back(fetch_v()); step("srai_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_RF, 4'b1101, 2'd0, 3'd1, 3'd0, 2'd3)); step("srai_exec");
    ir = I_SLLI;
    exp_q.push_back(fetch_v()); step("slli_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_RF, 4'b0001, 2'd0, 3'd1, 3'd0, 2'd3)); step("slli_exec");

    // lw with an interrupt pending during EXEC: must still go to WB
    ir = I_LW;
    exp_q.push_back(fetch_v()); step("lw_fetch");
    intr = 1'b1; mie = 1'b1;
    exp_q.push_back(ev(2'd1, E_RD2, 4'b0000, 2'd0, 3'd1, 3'd0, 2'd0)); step("lw_exec");
    intr = 1'b0;
    exp_q.push_back(ev(2'd2, E_PC | E_RF, 4'd0, 2'd0, 3'd0, 3'd0, 2'd2)); step("lw_wb");
    mie = 1'b0;

    // beq taken / not taken
    ir = I_BEQ; br_eq = 1'b1;
    exp_q.push_back(fetch_v()); step("beq_t_fetch");
    exp_q.push_back(ev(2'd1, E_PC, 4'd0, 2'd0, 3'd0, 3'd2, 2'd0)); step("beq_taken");
    br_eq = 1'b0; br_lt = 1'b1; br_ltu = 1'b1;
    exp_q.push_back(fetch_v()); step("beq_n_fetch");
    exp_q.push_back(ev(2'd1, E_PC, 4'd0, 2'd0, 3'd0, 3'd0, 2'd0)); step("beq_not_taken");
    br_lt = 1'b0; br_ltu = 1'b0;

    // sw, jal, csrrc, mret
    ir = I_SW;
    exp_q.push_back(fetch_v()); step("sw_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_WE2, 4'd0, 2'd0, 3'd2, 3'd0, 2'd0)); step("sw_exec");
    ir = I_JAL;
    exp_q.push_back(fetch_v()); step("jal_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_RF, 4'd0, 2'd0, 3'd0, 3'd3, 2'd0)); step("jal_exec");
    ir = I_CSRRC;
    exp_q.push_back(fetch_v()); step("csrrc_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_RF | E_CSR, 4'b0111, 2'd2, 3'd4, 3'd0, 2'd1)); step("csrrc_exec");
    ir = I_MRET;
    exp_q.push_back(fetch_v()); step("mret_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_MRET, 4'd0, 2'd0, 3'd0, 3'd5, 2'd0)); step("mret_exec");

    // add with interrupt enabled -> ST_INTR
    ir = I_ADD; intr = 1'b1; mie = 1'b1;
    exp_q.push_back(fetch_v()); step("add_i_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_RF, 4'b0000, 2'd0, 3'd0, 3'd0, 2'd3)); step("add_i_exec");
    mie = 1'b0;  // handler entry clears MIE; INTR stays high
    exp_q.push_back(ev(2'd3, E_PC | E_INT, 4'd0, 2'd0, 3'd0, 3'd4, 2'd0)); step("intr_entry");
    exp_q.push_back(fetch_v()); step("after_intr_fetch");
    exp_q.push_back(ev(2'd1, E_PC | E_RF, 4'b0000, 2'd0, 3'd0, 3'd0, 2'd3)); step("add_mie0_exec");
    exp_q.push_back(fetch_v()); step("mie0_no_intr");
    intr = 1'b0;

    // Reset asserted mid-EXEC for two cycles
    exp_q.push_back(ev(2'd1, E_PC | E_RF, 4'b0000, 2'd0, 3'd0, 3'd0, 2'd3)); step("pre_rst_exec");
    exp_q.push_back(fetch_v()); step("pre_rst_fetch");
    rst = 1'b1;
    exp_q.push_back(ev(2'd1, 8'h00, 4'd0, 2'd0, 3'd0, 3'd0, 2'd0)); step("rst_mid_exec");
    exp_q.push_back(ev(2'd0, 8'h00, 4'd0, 2'd0, 3'd0, 3'd0, 2'd0)); step("rst_hold");
    rst = 1'b0;
    exp_q.push_back(fetch_v()); step("rst_release_fetch");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: observed=%0d entries expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
